mem_port_arbiter: RTL

//   Shares one single-ported memory bus between instruction fetch (I-port) and the memory stage (D-port).

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch (I) and the memory stage (D).
// Latency: request seen in cycle N -> bus_req_o at N+1 -> done pulse at N+3 at the earliest.
// Backpressure: one transaction in flight; the losing or waiting port sees its stall_o held high.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    input  logic                i_flush_i,
    output logic                i_done_o,
    output logic [XLEN-1:0]     i_rdata_o,
    output logic                i_stall_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [XLEN-1:0]     d_wdata_i,
    input  logic [XLEN/8-1:0]   d_wstrb_i,
    output logic                d_done_o,
    output logic [XLEN-1:0]     d_rdata_o,
    output logic                d_stall_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [XLEN-1:0]     bus_wdata_o,
    output logic [XLEN/8-1:0]   bus_wstrb_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [XLEN-1:0]     bus_rdata_i,
    output logic                err_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0] TO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    logic [1:0]        state_q, state_d;
    logic              owner_i_q, owner_i_d;
    logic              flushed_q, flushed_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [7:0]        to_cnt_q, to_cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [XLEN/8-1:0] bus_wstrb_q, bus_wstrb_d;
    logic              i_done_q, i_done_d;
    logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
    logic              d_done_q, d_done_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic i_cand, pick_i, timeout_hit, finish, abort, i_dropped;

    assign i_cand      = i_req_i & ~i_flush_i;
    assign pick_i      = i_cand & (~d_req_i | (starve_q == STARVE_LIM));
    assign timeout_hit = (TIMEOUT > 0) && (to_cnt_q == TO_LAST);
    // A flush arriving in the completion cycle still suppresses the fetch result.
    assign i_dropped   = flushed_q | i_flush_i;
    assign finish      = (state_q == ST_DATA) & bus_rvalid_i;
    assign abort       = ~finish & timeout_hit & (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        owner_i_d   = owner_i_q;
        flushed_d   = flushed_q;
        starve_d    = starve_q;
        to_cnt_d    = to_cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        i_done_d    = 1'b0;
        i_rdata_d   = '0;
        d_done_d    = 1'b0;
        d_rdata_d   = '0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d  = 8'd0;
                flushed_d = 1'b0;
                if (d_req_i | i_cand) begin
                    state_d   = ST_ADDR;
                    bus_req_d = 1'b1;
                    owner_i_d = pick_i;
                    if (pick_i) begin
                        starve_d    = '0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = i_addr_i;
                        bus_wdata_d = '0;
                        bus_wstrb_d = '0;
                    end else begin
                        if (i_req_i && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
                        bus_we_d    = d_we_i;
                        bus_addr_d  = d_addr_i;
                        bus_wdata_d = d_wdata_i;
                        bus_wstrb_d = d_wstrb_i;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                to_cnt_d = to_cnt_q + 8'd1;
                if (owner_i_q & i_flush_i) flushed_d = 1'b1;
                if (finish | abort) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    flushed_d = 1'b0;
                    to_cnt_d  = 8'd0;
                    err_d     = abort;
                    if (owner_i_q) begin
                        i_done_d  = ~i_dropped;
                        i_rdata_d = (finish & ~i_dropped) ? bus_rdata_i : '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = (finish & ~bus_we_q) ? bus_rdata_i : '0;
                    end
                end else if (state_q == ST_ADDR && bus_gnt_i) begin
                    state_d   = ST_DATA;
                    bus_req_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_i_q   <= 1'b0;
            flushed_q   <= 1'b0;
            starve_q    <= '0;
            to_cnt_q    <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            i_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_i_q   <= owner_i_d;
            flushed_q   <= flushed_d;
            starve_q    <= starve_d;
            to_cnt_q    <= to_cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            i_done_q    <= i_done_d;
            i_rdata_q   <= i_rdata_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wstrb_o = bus_wstrb_q;
    assign i_done_o    = i_done_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_done_o    = d_done_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign i_stall_o   = i_req_i & ~i_done_q;
    assign d_stall_o   = d_req_i & ~d_done_q;
endmodule
